// File: rtl/pwm_duty_ctrl.sv
// Push-button duty-cycle controller: sync + debounce per button, saturating step, commit on PWM period boundary.
// Optional hold-to-repeat enabled by defining PWM_DUTY_CTRL_AUTO_REPEAT_EN.
module pwm_duty_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned DUTY_INIT  = 50,
    parameter int unsigned DUTY_STEP  = 5,
    parameter int unsigned DUTY_MIN   = 5,
    parameter int unsigned DUTY_MAX   = 95
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
    ,
    parameter int unsigned REP_DELAY  = 25000000,
    parameter int unsigned REP_PERIOD = 5000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_inc,
    input  logic       pb_dec,
    input  logic       period_end,
    output logic [6:0] duty,
    output logic       duty_upd,
    output logic       at_min,
    output logic       at_max
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [7:0] STEP8 = 8'(DUTY_STEP);
    localparam logic [7:0] MIN8  = 8'(DUTY_MIN);
    localparam logic [7:0] MAX8  = 8'(DUTY_MAX);

    typedef enum logic [1:0] {IDLE, ARMED, COMMIT, WAIT_REL} state_t;

    // Bit 0 = increment button, bit 1 = decrement button.
    logic [1:0]    s1_q, s2_q, deb_q, fall_q;
    logic [DW-1:0] cnt_q [2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= '1;
            s2_q   <= '1;
            deb_q  <= '1;
            fall_q <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            s1_q   <= {pb_dec, pb_inc};
            s2_q   <= s1_q;
            fall_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                if (s2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                        deb_q[i]  <= s2_q[i];
                        cnt_q[i]  <= '0;
                        fall_q[i] <= ~s2_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    logic inc_press, dec_press;
    assign inc_press = fall_q[0];
    assign dec_press = fall_q[1];

    state_t     state_q, state_d;
    logic       dir_q, dir_d;
    logic [6:0] nxt_q, nxt_d;
    logic [6:0] duty_q, duty_d;
    logic       upd_q, upd_d;
    logic       at_min_q, at_max_q;
    logic [7:0] duty8, sum8;
    logic [6:0] step_val;

`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned HW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    logic [HW-1:0] hold_q, hold_d, hold_thr;
    logic          rep_q, rep_d;
    assign hold_thr = rep_q ? HW'(REP_PERIOD - 1) : HW'(REP_DELAY - 1);
`endif

    // 8-bit intermediate keeps the clamp free of 7-bit wrap in both directions.
    always_comb begin
        duty8 = {1'b0, duty_q};
        if (dir_q) begin
            sum8     = duty8 + STEP8;
            step_val = (sum8 > MAX8) ? 7'(MAX8) : 7'(sum8);
        end else begin
            sum8     = duty8 - STEP8;
            step_val = (duty8 < (MIN8 + STEP8)) ? 7'(MIN8) : 7'(sum8);
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        nxt_d   = nxt_q;
        duty_d  = duty_q;
        upd_d   = 1'b0;
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
        hold_d  = hold_q;
        rep_d   = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
                hold_d = '0;
                rep_d  = 1'b0;
`endif
                if (inc_press && dec_press) begin
                    state_d = WAIT_REL;
                end else if (inc_press) begin
                    dir_d   = 1'b1;
                    state_d = ARMED;
                end else if (dec_press) begin
                    dir_d   = 1'b0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (dir_q ? dec_press : inc_press) begin
                    state_d = WAIT_REL;
                end else if (period_end) begin
                    nxt_d   = step_val;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (nxt_q != duty_q) begin
                    duty_d = nxt_q;
                    upd_d  = 1'b1;
                end
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (&deb_q) begin
                    state_d = IDLE;
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
                end else if (deb_q[0] ^ deb_q[1]) begin
                    if (hold_q == hold_thr) begin
                        hold_d  = '0;
                        rep_d   = 1'b1;
                        dir_d   = ~deb_q[0];
                        state_d = ARMED;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    hold_d = '0;
                    rep_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            nxt_q    <= 7'(DUTY_INIT);
            duty_q   <= 7'(DUTY_INIT);
            upd_q    <= 1'b0;
            at_min_q <= (DUTY_INIT == DUTY_MIN);
            at_max_q <= (DUTY_INIT == DUTY_MAX);
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
            hold_q   <= '0;
            rep_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            nxt_q    <= nxt_d;
            duty_q   <= duty_d;
            upd_q    <= upd_d;
            at_min_q <= (duty_d == 7'(MIN8));
            at_max_q <= (duty_d == 7'(MAX8));
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
            hold_q   <= hold_d;
            rep_q    <= rep_d;
`endif
        end
    end

    assign duty     = duty_q;
    assign duty_upd = upd_q;
    assign at_min   = at_min_q;
    assign at_max   = at_max_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with short debounce and a period_end pulse every 50 cycles.
module tb_pwm_duty_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pb_inc = 1'b1;
    logic       pb_dec = 1'b1;
    logic       period_end = 1'b0;
    logic [6:0] duty;
    logic       duty_upd;
    logic       at_min;
    logic       at_max;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int upd_cnt  = 0;
    int last_upd = -1;
    int last_pe  = -1;
    int last_lat = -1;

    pwm_duty_ctrl #(
        .DEB_CYCLES(4)
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
        ,
        .REP_DELAY (40),
        .REP_PERIOD(20)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_inc    (pb_inc),
        .pb_dec    (pb_dec),
        .period_end(period_end),
        .duty      (duty),
        .duty_upd  (duty_upd),
        .at_min    (at_min),
        .at_max    (at_max)
    );

    always #5 clk = ~clk;

    // Cycle numbering, period_end generation and duty_upd bookkeeping all live on the falling edge.
    always @(negedge clk) begin
        if (duty_upd) begin
            upd_cnt  = upd_cnt + 1;
            last_upd = cyc;
            last_lat = cyc - last_pe;
        end
        cyc        = cyc + 1;
        period_end = (cyc % 50 == 0);
        if (period_end) last_pe = cyc;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic wait_phase(input int ph);
        tick(1);
        for (int i = 0; i < 50 && (cyc % 50) != ph; i++) tick(1);
    endtask

    // which: 0 = inc, 1 = dec, 2 = both
    task automatic press(input int which, input int hold, input int settle);
        if (which != 1) pb_inc = 1'b0;
        if (which != 0) pb_dec = 1'b0;
        tick(hold);
        pb_inc = 1'b1;
        pb_dec = 1'b1;
        tick(settle);
    endtask

    initial begin
        int u0;
        int c0;
        int exp_duty;

        // Reset
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rst_duty", int'(duty), 50);
        check("rst_upd", int'(duty_upd), 0);
        check("rst_at_min", int'(at_min), 0);
        check("rst_at_max", int'(at_max), 0);

        // Single increment with commit timing
        wait_phase(10);
        c0 = cyc;
        u0 = upd_cnt;
        press(0, 30, 60);
        check("inc1_duty", int'(duty), 55);
        check("inc1_upd_cnt", upd_cnt - u0, 1);
        check("inc1_lat_after_pe", last_lat, 1);
        check("inc1_upd_cycle", last_upd - c0, 41);
        for (int i = 0; i < 3; i++) press(0, 30, 60);
        check("inc4_duty", int'(duty), 70);
        check("inc4_upd_cnt", upd_cnt - u0, 4);
        check("inc4_at_max", int'(at_max), 0);

        // Lower limit
        do_reset();
        u0 = upd_cnt;
        exp_duty = 50;
        for (int i = 0; i < 14; i++) begin
            press(1, 30, 60);
            exp_duty = (exp_duty - 5 < 5) ? 5 : exp_duty - 5;
            check("dec_duty", int'(duty), exp_duty);
        end
        check("dec_upd_cnt", upd_cnt - u0, 9);
        check("dec_at_min", int'(at_min), 1);
        check("dec_at_max", int'(at_max), 0);

        // Bounce shorter than the debounce window
        u0 = upd_cnt;
        for (int i = 0; i < 5; i++) begin
            pb_inc = 1'b0;
            tick(2);
            pb_inc = 1'b1;
            tick(2);
        end
        tick(80);
        check("bounce_duty", int'(duty), 5);
        check("bounce_upd", upd_cnt - u0, 0);

        // Both buttons together, then a normal press proves the FSM is back in IDLE
        press(2, 30, 60);
        check("both_duty", int'(duty), 5);
        check("both_upd", upd_cnt - u0, 0);
        press(0, 30, 60);
        check("after_both_duty", int'(duty), 10);
        check("after_both_at_min", int'(at_min), 0);

        // Second button while ARMED cancels the request
        u0 = upd_cnt;
        wait_phase(1);
        pb_inc = 1'b0;
        tick(10);
        pb_dec = 1'b0;
        tick(20);
        pb_inc = 1'b1;
        pb_dec = 1'b1;
        tick(80);
        check("cancel_duty", int'(duty), 10);
        check("cancel_upd", upd_cnt - u0, 0);

        // period_end in the same cycle as the press is ignored; the next one commits
        wait_phase(44);
        c0 = cyc;
        press(0, 30, 60);
        check("pe_coincide_duty", int'(duty), 15);
        check("pe_coincide_upd_cycle", last_upd - c0, 57);

        // Reset while ARMED
        wait_phase(1);
        u0 = upd_cnt;
        pb_inc = 1'b0;
        tick(15);
        rst = 1'b0;
        pb_inc = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst_duty", int'(duty), 50);
        check("midrst_upd", upd_cnt - u0, 0);
        tick(80);
        check("midrst_late_duty", int'(duty), 50);
        check("midrst_late_upd", upd_cnt - u0, 0);

`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
        // Hold-to-repeat
        do_reset();
        wait_phase(1);
        u0 = upd_cnt;
        press(0, 200, 20);
        check("rep_duty", int'(duty), 70);
        check("rep_upd_cnt", upd_cnt - u0, 4);
        u0 = upd_cnt;
        press(0, 600, 80);
        check("rep_sat_duty", int'(duty), 95);
        check("rep_sat_at_max", int'(at_max), 1);
        check("rep_sat_upd_cnt", upd_cnt - u0, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Duty-cycle controller that sits in front of the PWM core. It takes the two active-low push-buttons and produces the duty-cycle command the core consumes.
- Each button is synchronised, debounced and edge-detected.
- The duty register is stepped up or down with saturation.
- New values are committed only at a PWM period boundary, so the output never glitches mid-period.
- Optional auto-repeat when a button is held.

Parameters:
DEB_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz)
DUTY_INIT, 50, duty (percent) after reset
DUTY_STEP, 5, percent added/subtracted per accepted press
DUTY_MIN, 5, lower saturation limit (percent)
DUTY_MAX, 95, upper saturation limit (percent)
REP_DELAY, 25000000, hold cycles before first auto-repeat (AUTO_REPEAT_EN only)
REP_PERIOD, 5000000, cycles between subsequent repeats (AUTO_REPEAT_EN only)

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
pb_inc  input  1  increment button, active-low, asynchronous to clk
pb_dec  input  1  decrement button, active-low, asynchronous to clk
period_end  input  1  one-cycle pulse from PWM core on last cycle of each PWM period
duty  output  7  committed duty in percent, range DUTY_MIN..DUTY_MAX
duty_upd  output  1  one-cycle pulse in the cycle duty first shows a new value
at_min  output  1  high while duty == DUTY_MIN
at_max  output  1  high while duty == DUTY_MAX

Behaviour:
- Reset (rst=0 at a clk edge): all registers cleared and FSM forced to IDLE, regardless of current state.
  - duty=DUTY_INIT, duty_upd=0, at_min/at_max derived from DUTY_INIT.
  - Synchronisers preset to 1 (released); debounced levels = released.
  - Pending request cleared.
- Synchroniser: 2 flops per button.
- Debounce, per button:
  - Counter runs while the synced level differs from the debounced level; it resets to 0 whenever they match.
  - Debounced level flips when the counter reaches DEB_CYCLES-1.
  - Total latency from pin edge to debounced edge = 2 + DEB_CYCLES cycles.
- Press event = debounced falling edge (1->0), one cycle wide.
- FSM states:
  - IDLE: inc press -> pending=+1, go ARMED; dec press -> pending=-1, go ARMED.
  - ARMED: wait for period_end=1. On that edge compute nxt = duty +/- DUTY_STEP, clamp to [DUTY_MIN, DUTY_MAX], go COMMIT.
  - COMMIT: if nxt != duty, load duty and pulse duty_upd for one cycle; otherwise no pulse. Clear pending, go WAIT_REL.
  - WAIT_REL: stay until both debounced levels are released (1), then go IDLE.
- Arithmetic: 8-bit intermediate; no unsigned wrap below 0 or above 127. Result is clamped, e.g. 93+5 -> 95 and 7-5 -> 5.
- Simultaneous presses (both debounced low in the same cycle, or the second arrives while ARMED):
  - In IDLE both pressed: no request; go straight to WAIT_REL.
  - Second press while ARMED cancels the pending request and goes to WAIT_REL; duty is unchanged.
- Presses arriving in ARMED/COMMIT/WAIT_REL are not queued; at most one step per press-release cycle.
- period_end coinciding with the press event: it is not used; the commit waits for the next period_end.
- at_min/at_max are registered and update in the same cycle as duty.
- Mid-operation reset discards any pending request; duty returns to DUTY_INIT with no duty_upd pulse.

Optional Feature:
Macro: PWM_DUTY_CTRL_AUTO_REPEAT_EN
- Defined:
  - In WAIT_REL with exactly one button held, a hold counter runs.
  - At REP_DELAY, then every REP_PERIOD, a repeat request in the same direction is set and the FSM goes to ARMED.
  - Clamping applies, so holding at a limit produces no duty_upd.
  - Releasing or pressing the other button resets the hold counter.
- Undefined: hold counter and REP_* logic are absent; one step per press.

Test Plan:
(Bench overrides: DEB_CYCLES=4, REP_DELAY=40, REP_PERIOD=20; period_end pulses every 50 cycles.)
1. Reset: release rst after 2 cycles -> duty=50, duty_upd=0, at_min=0, at_max=0.
2. Single inc: pb_inc low for 30 cycles -> duty 50->55 one cycle after the first period_end following the debounced edge; exactly one duty_upd pulse. 3 more presses -> 70.
3. Lower limit: 14 dec presses from 50 -> duty 45,40,...,5, then stays 5; at_min=1; no duty_upd once at 5.
4. Bounce and simultaneity: pb_inc toggling every 2 cycles for 20 cycles -> no change. Both buttons low together -> no change, FSM returns to IDLE after both are released.
5. Reset mid-operation: press inc, assert rst while ARMED -> duty=50, no duty_upd, and no commit at the next period_end.
6. With PWM_DUTY_CTRL_AUTO_REPEAT_EN: hold pb_inc 200 cycles from 50 -> one step at the press plus one per repeat. Saturates at 95 with at_max=1.
